// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifu_state_t;

    // Next-PC source select for the PC register
    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_BR   = 2'd1,
        PC_PEND = 2'd2
    } pc_src_t;

    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    // Fetch addresses are always word aligned; low two bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_imem_if.sv
// Instruction-memory request/response bundle.
interface ifu_imem_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        imem_busywait;

    modport master (output imem_read, imem_address, input imem_readdata, imem_busywait);
    modport slave  (input imem_read, imem_address, output imem_readdata, imem_busywait);
endinterface

// File: rtl/ifu_pc_reg.sv
// PC and pending-redirect storage with next-PC selection and +4 adder.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_ld,
    input  pc_src_t     pc_src,
    input  logic        pend_we,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4
);

    logic [31:0] pend;
    logic [31:0] target_al;
    logic [31:0] pc_nxt;

    assign target_al = word_align(branch_target);
    assign pc_plus_4 = pc + 32'd4;   // wraps modulo 2^32

    // Next-PC mux; a branch arriving in the same cycle beats the stored target
    always_comb begin
        pc_nxt = pc_plus_4;
        case (pc_src)
            PC_INC:  pc_nxt = pc_plus_4;
            PC_BR:   pc_nxt = target_al;
            PC_PEND: pc_nxt = pend;
            default: pc_nxt = pc_plus_4;
        endcase
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      pc <= word_align(RESET_PC);
        else if (pc_ld) pc <= pc_nxt;
    end

    // Pending redirect captured while an access is draining
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pend <= 32'h0;
        else if (pend_we) pend <= target_al;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the instruction memory, hands fetched
// words to IF/ID and handles redirects, including ones that land while
// a memory access is still in flight (DRAIN).
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              stall,
    ifu_imem_if.master        imem,
    output logic [31:0]       OUT_pc,
    output logic [31:0]       OUT_pc_plus_4,
    output logic [31:0]       OUT_instruction,
    output logic              busywait
);

    ifu_state_t  state, state_nxt;
    logic        pc_ld, pend_we, bubble, mem_read;
    pc_src_t     pc_src;
    logic [31:0] pc, pc_plus_4;

    ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .pc_ld         (pc_ld),
        .pc_src        (pc_src),
        .pend_we       (pend_we),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus_4     (pc_plus_4)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // Next state, PC control and handshake outputs
    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        pc_src    = PC_INC;
        pend_we   = 1'b0;
        mem_read  = 1'b1;
        busywait  = 1'b1;
        bubble    = 1'b0;
        if (reset) begin
            mem_read = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        bubble   = 1'b1;
                        busywait = 1'b0;
                        if (!imem.imem_busywait) begin
                            pc_ld  = 1'b1;
                            pc_src = PC_BR;
                        end else begin
                            // in-flight access cannot be aborted; park the target
                            pend_we   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (!stall && !imem.imem_busywait) begin
                        busywait = 1'b0;
                        pc_ld    = 1'b1;
                        pc_src   = PC_INC;
                    end
                end
                DRAIN: begin
                    bubble   = 1'b1;
                    busywait = 1'b0;
                    pend_we  = branch_taken;
                    if (!imem.imem_busywait) begin
                        pc_ld     = 1'b1;
                        pc_src    = branch_taken ? PC_BR : PC_PEND;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // IF/ID payload: zeros in reset, NOP bubble on redirect, else the fetch
    always_comb begin
        OUT_pc          = pc;
        OUT_pc_plus_4   = pc_plus_4;
        OUT_instruction = imem.imem_readdata;
        if (reset) begin
            OUT_pc          = 32'h0;
            OUT_pc_plus_4   = 32'h0;
            OUT_instruction = 32'h0;
        end else if (bubble) begin
            OUT_pc          = 32'h0;
            OUT_pc_plus_4   = 32'h0;
            OUT_instruction = IFU_NOP;
        end
    end

    assign imem.imem_read    = mem_read;
    assign imem.imem_address = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_instruction_fetch_unit;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        mbusy;
    logic [31:0] OUT_pc, OUT_pc_plus_4, OUT_instruction;
    logic        busywait;

    int n_total = 0;
    int n_pass  = 0;

    ifu_imem_if mem_if();

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign mem_if.imem_readdata = mem_word(mem_if.imem_address);
    assign mem_if.imem_busywait = mbusy;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .stall           (stall),
        .imem            (mem_if.master),
        .OUT_pc          (OUT_pc),
        .OUT_pc_plus_4   (OUT_pc_plus_4),
        .OUT_instruction (OUT_instruction),
        .busywait        (busywait)
    );

    // Reference model: architectural PC, redirect-in-flight flag, parked target
    logic [31:0] m_pc = 32'h0, m_pend = 32'h0;
    bit          m_drain = 1'b0;
    // Expected outputs for the current cycle
    logic        e_read, e_busy, e_chk_out;
    logic [31:0] e_addr, e_opc, e_opp4, e_instr;

    // Apply inputs away from the rising edge and work out expected outputs
    task automatic drive(input logic r, input logic br, input logic [31:0] t,
                         input logic st, input logic mb);
        @(negedge clk);
        reset = r; branch_taken = br; branch_target = t; stall = st; mbusy = mb;
        if (r) begin m_pc = 32'h0; m_pend = 32'h0; m_drain = 1'b0; end
        #1;
        e_addr = m_pc; e_chk_out = 1'b1;
        if (r) begin
            e_read = 0; e_busy = 1; e_opc = 0; e_opp4 = 0; e_instr = 0;
        end else begin
            e_read = 1;
            if (m_drain || br) begin
                e_busy = 0; e_opc = 0; e_opp4 = 0; e_instr = 32'h0000_0013;
            end else if (st || mb) begin
                e_busy = 1; e_chk_out = 0;
            end else begin
                e_busy = 0; e_opc = m_pc; e_opp4 = m_pc + 32'd4; e_instr = mem_word(m_pc);
            end
        end
    endtask

    // Advance the model across one rising edge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0; m_pend = 32'h0; m_drain = 1'b0;
        end else if (m_drain) begin
            if (branch_taken) m_pend = branch_target & ~32'h3;
            if (!mbusy) begin m_pc = m_pend; m_drain = 1'b0; end
        end else if (branch_taken) begin
            if (!mbusy) m_pc = branch_target & ~32'h3;
            else begin m_pend = branch_target & ~32'h3; m_drain = 1'b1; end
        end else if (!stall && !mbusy) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        n_total++; if (mem_if.imem_read !== 1'b0) $display("FAIL rst_read got %b want 0", mem_if.imem_read); else n_pass++;
        n_total++; if (busywait !== 1'b1) $display("FAIL rst_busy got %b want 1", busywait); else n_pass++;
        n_total++; if (OUT_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", OUT_pc); else n_pass++;
        n_total++; if (OUT_pc_plus_4 !== 32'h0) $display("FAIL rst_pp4 got %h want 0", OUT_pc_plus_4); else n_pass++;
        n_total++; if (OUT_instruction !== 32'h0) $display("FAIL rst_instr got %h want 0", OUT_instruction); else n_pass++;
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            n_total++; if (mem_if.imem_address !== 32'(i * 4)) $display("FAIL seq_addr got %h want %h", mem_if.imem_address, 32'(i * 4)); else n_pass++;
            n_total++; if (OUT_pc_plus_4 !== OUT_pc + 32'd4) $display("FAIL seq_pp4 got %h want %h", OUT_pc_plus_4, OUT_pc + 32'd4); else n_pass++;
            n_total++; if (busywait !== 1'b0) $display("FAIL seq_busy got %b want 0", busywait); else n_pass++;
            n_total++; if (OUT_instruction !== mem_word(32'(i * 4))) $display("FAIL seq_instr got %h want %h", OUT_instruction, mem_word(32'(i * 4))); else n_pass++;
            tick();
        end
    endtask

    task automatic test_latency();
        drive(0, 1, 32'h40, 0, 0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1);
            n_total++; if (busywait !== 1'b1) $display("FAIL lat_busy got %b want 1", busywait); else n_pass++;
            n_total++; if (mem_if.imem_address !== 32'h40) $display("FAIL lat_addr got %h want 40", mem_if.imem_address); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_total++; if (busywait !== 1'b0) $display("FAIL lat_done_busy got %b want 0", busywait); else n_pass++;
        n_total++; if (OUT_pc !== 32'h40) $display("FAIL lat_pc got %h want 40", OUT_pc); else n_pass++;
        n_total++; if (OUT_instruction !== mem_word(32'h40)) $display("FAIL lat_instr got %h want %h", OUT_instruction, mem_word(32'h40)); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 1);
        n_total++; if (mem_if.imem_address !== 32'h44) $display("FAIL lat_next got %h want 44", mem_if.imem_address); else n_pass++;
        tick();
    endtask

    task automatic test_branch_drain();
        drive(0, 1, 32'h10, 0, 0); tick();
        drive(0, 1, 32'h203, 0, 1);
        n_total++; if (OUT_instruction !== IFU_NOP) $display("FAIL bd_nop got %h want %h", OUT_instruction, IFU_NOP); else n_pass++;
        n_total++; if (busywait !== 1'b0) $display("FAIL bd_busy got %b want 0", busywait); else n_pass++;
        n_total++; if (OUT_pc !== 32'h0) $display("FAIL bd_pc got %h want 0", OUT_pc); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 1);
        n_total++; if (mem_if.imem_address !== 32'h10) $display("FAIL bd_drain_addr got %h want 10", mem_if.imem_address); else n_pass++;
        n_total++; if (mem_if.imem_read !== 1'b1) $display("FAIL bd_drain_read got %b want 1", mem_if.imem_read); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_total++; if (OUT_instruction !== IFU_NOP) $display("FAIL bd_discard got %h want %h", OUT_instruction, IFU_NOP); else n_pass++;
        n_total++; if (busywait !== 1'b0) $display("FAIL bd_discard_busy got %b want 0", busywait); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 1);
        n_total++; if (mem_if.imem_address !== 32'h200) $display("FAIL bd_target got %h want 200", mem_if.imem_address); else n_pass++;
        tick();
    endtask

    task automatic test_stall_branch();
        drive(0, 1, 32'h80, 0, 0); tick();
        drive(0, 0, 0, 1, 0);
        n_total++; if (busywait !== 1'b1) $display("FAIL sb_busy got %b want 1", busywait); else n_pass++;
        n_total++; if (mem_if.imem_read !== 1'b1) $display("FAIL sb_read got %b want 1", mem_if.imem_read); else n_pass++;
        tick();
        drive(0, 1, 32'h100, 1, 0);
        n_total++; if (mem_if.imem_address !== 32'h80) $display("FAIL sb_hold got %h want 80", mem_if.imem_address); else n_pass++;
        n_total++; if (OUT_instruction !== IFU_NOP) $display("FAIL sb_nop got %h want %h", OUT_instruction, IFU_NOP); else n_pass++;
        n_total++; if (busywait !== 1'b0) $display("FAIL sb_nop_busy got %b want 0", busywait); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_total++; if (OUT_pc !== 32'h100) $display("FAIL sb_target got %h want 100", OUT_pc); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFF, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        n_total++; if (mem_if.imem_address !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", mem_if.imem_address); else n_pass++;
        n_total++; if (OUT_pc_plus_4 !== 32'h0) $display("FAIL wrap_pp4 got %h want 0", OUT_pc_plus_4); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 1);
        n_total++; if (mem_if.imem_address !== 32'h0) $display("FAIL wrap_next got %h want 0", mem_if.imem_address); else n_pass++;
        tick();
    endtask

    task automatic test_reset_in_drain();
        drive(0, 1, 32'h50, 0, 0); tick();
        drive(0, 1, 32'h300, 0, 1); tick();
        drive(0, 0, 0, 0, 1);
        n_total++; if (OUT_instruction !== IFU_NOP) $display("FAIL rd_in_drain got %h want %h", OUT_instruction, IFU_NOP); else n_pass++;
        drive(1, 0, 0, 0, 1);
        n_total++; if (mem_if.imem_read !== 1'b0) $display("FAIL rd_abandon got %b want 0", mem_if.imem_read); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_total++; if (mem_if.imem_address !== 32'h0) $display("FAIL rd_restart got %h want 0", mem_if.imem_address); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_total++; if (mem_if.imem_address !== 32'h4) $display("FAIL rd_no_redirect got %h want 4", mem_if.imem_address); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 60) == 0, ($urandom % 6) == 0, $urandom,
                  ($urandom % 5) == 0, ($urandom % 3) == 0);
            n_total++; if (mem_if.imem_read !== e_read) $display("FAIL rnd_read cyc %0d got %b want %b", i, mem_if.imem_read, e_read); else n_pass++;
            n_total++; if (busywait !== e_busy) $display("FAIL rnd_busy cyc %0d got %b want %b", i, busywait, e_busy); else n_pass++;
            if (e_read) begin
                n_total++; if (mem_if.imem_address !== e_addr) $display("FAIL rnd_addr cyc %0d got %h want %h", i, mem_if.imem_address, e_addr); else n_pass++;
            end
            if (e_chk_out) begin
                n_total++; if (OUT_pc !== e_opc) $display("FAIL rnd_pc cyc %0d got %h want %h", i, OUT_pc, e_opc); else n_pass++;
                n_total++; if (OUT_pc_plus_4 !== e_opp4) $display("FAIL rnd_pp4 cyc %0d got %h want %h", i, OUT_pc_plus_4, e_opp4); else n_pass++;
                n_total++; if (OUT_instruction !== e_instr) $display("FAIL rnd_instr cyc %0d got %h want %h", i, OUT_instruction, e_instr); else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0; mbusy = 1'b0;
        test_reset();
        test_sequential();
        test_latency();
        test_branch_drain();
        test_stall_branch();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port branch_taken, input, 1, a redirect request from the execute stage.
REQ-005 The block SHALL have port branch_target, input, 32, the redirect address; bits [1:0] are ignored and treated as 0.
REQ-006 The block SHALL have port stall, input, 1, a hazard-unit request to hold the PC.
REQ-007 The block SHALL have ports imem_read, output, 1, and imem_address, output, 32, forming the instruction-memory request.
REQ-008 The block SHALL have ports imem_readdata, input, 32, and imem_busywait, input, 1; a fetch completes in any cycle with imem_read=1 and imem_busywait=0.
REQ-009 The block SHALL have ports OUT_pc, OUT_pc_plus_4 and OUT_instruction, each output, 32, driving the IF/ID register.
REQ-010 The block SHALL have port busywait, output, 1; it tells the IF/ID register not to capture.

Function
REQ-011 The FSM SHALL have two states: FETCH and DRAIN.
REQ-012 In FETCH, imem_read SHALL be 1 and imem_address SHALL equal the PC.
REQ-013 When a fetch completes in FETCH with branch_taken=0 and stall=0, the block SHALL present OUT_instruction=imem_readdata, OUT_pc=PC and OUT_pc_plus_4=PC+4 combinationally in that cycle, drive busywait=0, and load PC with PC+4 at the next edge.
REQ-014 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC to 32'h0000_0000).
REQ-015 In FETCH with imem_busywait=1 and branch_taken=0, busywait SHALL be 1 and the PC SHALL hold.
REQ-016 With stall=1 and branch_taken=0, busywait SHALL be 1, the PC SHALL hold, and imem_read SHALL remain 1; a completed fetch in that cycle SHALL be discarded and re-requested.
REQ-017 branch_taken=1 SHALL take priority over stall and over fetch completion.
REQ-018 In the branch cycle, the block SHALL drive OUT_instruction=NOP (32'h0000_0013), OUT_pc=0, OUT_pc_plus_4=0 and busywait=0, so that IF/ID captures a bubble.
REQ-019 A branch in FETCH with imem_busywait=0 SHALL load PC with {branch_target[31:2],2'b00} at the next edge and remain in FETCH.
REQ-020 A branch in FETCH with imem_busywait=1 SHALL store the aligned target in a pending register and transition to DRAIN, because the in-flight memory access cannot be aborted.
REQ-021 In DRAIN, the block SHALL keep imem_read=1 with the old address, output the NOP with busywait=0, and discard the returned data.
REQ-022 On imem_busywait=0 in DRAIN, the block SHALL load PC with the pending target and return to FETCH.
REQ-023 A further branch_taken in DRAIN SHALL overwrite the pending target.
REQ-024 imem_address SHALL always be word-aligned.

Reset
REQ-025 While reset=1, the PC SHALL be RESET_PC, the state SHALL be FETCH, the pending target SHALL be 0, imem_read SHALL be 0, busywait SHALL be 1, and OUT_* SHALL be 0.
REQ-026 Reset asserted mid-fetch or in DRAIN SHALL abandon the access immediately, with no redirect retained.
REQ-027 On the first edge after reset deasserts, the block SHALL request RESET_PC.

Structure
REQ-028 Package ifu_pkg SHALL hold the state enum (FETCH, DRAIN), the NOP constant 32'h0000_0013 and the default RESET_PC.
REQ-029 One sub-module, ifu_pc_reg, SHALL hold the PC, the pending target, the next-PC mux and the +4 adder; the FSM and output muxing SHALL stay at top level.

Verification
REQ-030 Reset release with RESET_PC=0 and zero-wait memory -> imem_address sequence 0,4,8,C on consecutive cycles; OUT_pc_plus_4 equals OUT_pc+4; busywait=0.
REQ-031 3-cycle memory latency at PC=0x40 -> busywait=1 for 2 cycles, then instruction 0x40 is presented once and the PC becomes 0x44.
REQ-032 branch_taken with target 0x203 while the fetch of 0x10 is in flight (imem_busywait=1) -> NOP output with busywait=0 that cycle, the FSM enters DRAIN, 0x10 data is discarded, and the next request is 0x200.
REQ-033 stall=1 for 2 cycles at PC=0x80 together with branch_taken (target 0x100) on the second cycle -> the PC holds 0x80, then NOP is output, then 0x100 is fetched.
REQ-034 PC=0xFFFF_FFFC with fetch complete -> next imem_address=0x0000_0000.
REQ-035 reset pulsed in DRAIN with a pending target of 0x300 -> after release, the fetch starts at RESET_PC, not 0x300.
